mat_operand_stream_buffer: RTL and testbench



---
 rtl/mat_operand_stream_buffer.sv | 196 +++++++++++++++++++
 tb/tb_mat_operand_stream_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_operand_stream_buffer.sv
// Operand buffer for the MAC array.
// Loads W (row-major) then X (row-major) through a valid/ready port.
// It then streams one inner-product step per beat: column k of W and row k of X.
// The stored operands can be replayed without reloading them.
module mat_operand_stream_buffer #(
    parameter int unsigned DW   = 4,
    parameter int unsigned N    = 3,
    parameter int unsigned DIMW = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              replay,
    input  logic [DIMW-1:0]   row_w,
    input  logic [DIMW-1:0]   col_w,
    input  logic [DIMW-1:0]   row_x,
    input  logic [DIMW-1:0]   col_x,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N*DW-1:0]   out_w,
    output logic [N*DW-1:0]   out_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              done,
    output logic              busy,
    output logic              dim_err
);

    localparam int unsigned CW = $clog2(N * N + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DIMW-1:0] row_w_q, col_w_q, row_x_q, col_x_q;
    logic [CW-1:0]   r_q, c_q, k_q;
    logic            loaded_q;
    logic            dim_err_q;

    logic [DW-1:0]   mem_w [N][N];
    logic [DW-1:0]   mem_x [N][N];

    logic [DIMW-1:0] cur_rows, cur_cols;
    logic            dims_ok, start_ok, start_bad, replay_go;
    logic            loading, in_fire, row_end, load_last;
    logic            k_last, out_fire;

    logic [IW-1:0]   r_idx, c_idx, k_idx;
    assign r_idx = r_q[IW-1:0];
    assign c_idx = c_q[IW-1:0];
    assign k_idx = k_q[IW-1:0];

    function automatic logic dim_in_range(input logic [DIMW-1:0] d);
        return (d != '0) && (d <= DIMW'(N));
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake qualifiers
    always_comb begin
        state_d   = state_q;
        cur_rows  = row_w_q;
        cur_cols  = col_w_q;
        dims_ok   = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        replay_go = 1'b0;
        loading   = 1'b0;
        in_fire   = 1'b0;
        row_end   = 1'b0;
        load_last = 1'b0;
        k_last    = 1'b0;
        out_fire  = 1'b0;

        if (state_q == S_LOAD_X) begin
            cur_rows = row_x_q;
            cur_cols = col_x_q;
        end
        dims_ok   = dim_in_range(row_w) && dim_in_range(col_w) &&
                    dim_in_range(row_x) && dim_in_range(col_x) && (col_w == row_x);
        loading   = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
        in_fire   = loading && in_valid;
        row_end   = (c_q == CW'(cur_cols - DIMW'(1)));
        load_last = row_end && (r_q == CW'(cur_rows - DIMW'(1)));
        k_last    = (k_q == CW'(col_w_q - DIMW'(1)));
        out_fire  = (state_q == S_STREAM) && out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_ok  = dims_ok;
                    start_bad = !dims_ok;
                    if (dims_ok) state_d = S_LOAD_W;
                end else if (replay && loaded_q) begin
                    replay_go = 1'b1;
                    state_d   = S_STREAM;
                end
            end
            S_LOAD_W: if (in_fire && load_last) state_d = S_LOAD_X;
            S_LOAD_X: if (in_fire && load_last) state_d = S_STREAM;
            S_STREAM: if (out_fire && k_last)   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Dimension latch, load/stream counters, loaded flag, error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            row_w_q   <= '0;
            col_w_q   <= '0;
            row_x_q   <= '0;
            col_x_q   <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            loaded_q  <= 1'b0;
            dim_err_q <= 1'b0;
        end else begin
            dim_err_q <= start_bad;
            if (start_ok) begin
                row_w_q  <= row_w;
                col_w_q  <= col_w;
                row_x_q  <= row_x;
                col_x_q  <= col_x;
                r_q      <= '0;
                c_q      <= '0;
                loaded_q <= 1'b0;
            end
            if (in_fire) begin
                if (row_end) begin
                    c_q <= '0;
                    r_q <= load_last ? '0 : r_q + CW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
                if (load_last && (state_q == S_LOAD_X)) begin
                    loaded_q <= 1'b1;
                    k_q      <= '0;
                end
            end
            if (replay_go) k_q <= '0;
            if (out_fire)  k_q <= k_last ? '0 : k_q + CW'(1);
        end
    end

    // Operand storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    mem_w[i][j] <= '0;
                    mem_x[i][j] <= '0;
                end
            end
        end else if (in_fire) begin
            if (state_q == S_LOAD_W) mem_w[r_idx][c_idx] <= in_data;
            else                     mem_x[r_idx][c_idx] <= in_data;
        end
    end

    // Lane drive: W column k and X row k, lanes beyond the live dimension held at 0
    always_comb begin
        out_w = '0;
        out_x = '0;
        if (state_q == S_STREAM) begin
            for (int i = 0; i < int'(N); i++) begin
                if (DIMW'(i) < row_w_q) out_w[i*DW +: DW] = mem_w[i][k_idx];
                if (DIMW'(i) < col_x_q) out_x[i*DW +: DW] = mem_x[k_idx][i];
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign out_valid = (state_q == S_STREAM);
    assign out_first = (state_q == S_STREAM) && (k_q == '0);
    assign out_last  = (state_q == S_STREAM) && k_last;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign dim_err   = dim_err_q;

endmodule

// File: tb/tb_mat_operand_stream_buffer.sv
// Self-checking bench for mat_operand_stream_buffer against a matrix-level model.
module tb_mat_operand_stream_buffer;

    localparam int DW   = 4;
    localparam int N    = 3;
    localparam int DIMW = 3;

    logic            clk = 1'b0;
    logic            rst, start, replay, in_valid, out_ready;
    logic [DIMW-1:0] row_w, col_w, row_x, col_x;
    logic [DW-1:0]   in_data;
    logic            in_ready, out_valid, out_first, out_last, done, busy, dim_err;
    logic [N*DW-1:0] out_w, out_x;

    int vectors = 0;
    int fails   = 0;

    int mw [N][N];
    int mx [N][N];
    int m_rw, m_cw, m_rx, m_cx;

    mat_operand_stream_buffer #(.DW(DW), .N(N), .DIMW(DIMW)) dut (
        .clk(clk), .rst(rst), .start(start), .replay(replay),
        .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_w(out_w), .out_x(out_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .done(done), .busy(busy),
        .dim_err(dim_err)
    );

    always #5 clk = ~clk;

    // Column k of W on the lanes, zero beyond the row count
    function automatic logic [N*DW-1:0] exp_w(input int k);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (i < m_rw) v[i*DW +: DW] = DW'(mw[i][k]);
        return v;
    endfunction

    // Row k of X on the lanes, zero beyond the column count
    function automatic logic [N*DW-1:0] exp_x(input int k);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (j < m_cx) v[j*DW +: DW] = DW'(mx[k][j]);
        return v;
    endfunction

    // Element idx of the serial load order: W row-major then X row-major
    function automatic int elem(input int idx);
        int nw = m_rw * m_cw;
        if (idx < nw) return mw[idx / m_cw][idx % m_cw];
        return mx[(idx - nw) / m_cx][(idx - nw) % m_cx];
    endfunction

    task automatic fill_seq(input int rw, input int cw, input int cx, input int wbase, input int xstep);
        m_rw = rw; m_cw = cw; m_rx = cw; m_cx = cx;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mw[r][c] = (wbase + r * cw + c) & 15;
                mx[r][c] = (xstep > 0) ? ((1 + r * cx + c) & 15) : ((9 - (r * cx + c)) & 15);
            end
    endtask

    task automatic fill_rand(input int rw, input int cw, input int cx);
        m_rw = rw; m_cw = cw; m_rx = cw; m_cx = cx;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mw[r][c] = int'($urandom_range(15));
                mx[r][c] = int'($urandom_range(15));
            end
    endtask

    // Start with the model dimensions and push all elements; optional abort point
    task automatic load(input int gap_pct, input int abort_after);
        int idx = 0;
        int cyc = 0;
        int total = m_rw * m_cw + m_rx * m_cx;
        row_w = DIMW'(m_rw); col_w = DIMW'(m_cw);
        row_x = DIMW'(m_rx); col_x = DIMW'(m_cx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({in_ready, busy, dim_err} !== 3'b110)
            $display("FAIL load_enter got rdy/busy/err=%b%b%b want 110", in_ready, busy, dim_err);
        while (idx < total && cyc < 500) begin
            if (abort_after >= 0 && idx == abort_after) break;
            cyc++;
            vectors++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL load_ready idx=%0d got in_ready=%b want 1", idx, in_ready);
            end
            if (int'($urandom_range(99)) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = DW'(elem(idx));
                idx++;
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom_range(15));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (abort_after < 0) begin
            vectors++;
            if (idx != total || {out_valid, out_first, in_ready} !== 3'b110) begin
                fails++;
                $display("FAIL load_to_stream idx=%0d/%0d got valid/first/rdy=%b%b%b want 110",
                         idx, total, out_valid, out_first, in_ready);
            end
        end
    endtask

    // Consume a stream, checking every presented beat and hold under backpressure
    task automatic collect(input int exp_beats, input int ready_pct, input int stall_k, input int stall_n);
        int beats = 0;
        int cyc = 0;
        int stall_left = stall_n;
        bit hold = 1'b0;
        bit rdy;
        logic ef, el;
        logic [N*DW-1:0] pw = '0, px = '0;
        while (beats < exp_beats && cyc < 300) begin
            cyc++;
            if (hold) begin
                vectors++;
                if ({out_valid, out_w, out_x} !== {1'b1, pw, px}) begin
                    fails++;
                    $display("FAIL stream_hold k=%0d got v=%b w=%h x=%h want v=1 w=%h x=%h",
                             beats, out_valid, out_w, out_x, pw, px);
                end
            end
            if (out_valid) begin
                ef = (beats == 0);
                el = (beats == exp_beats - 1);
                vectors++;
                if ({out_w, out_x, out_first, out_last, in_ready} !==
                    {exp_w(beats), exp_x(beats), ef, el, 1'b0}) begin
                    fails++;
                    $display("FAIL stream_beat k=%0d got w=%h x=%h f=%b l=%b rdy=%b want w=%h x=%h f=%b l=%b rdy=0",
                             beats, out_w, out_x, out_first, out_last, in_ready,
                             exp_w(beats), exp_x(beats), ef, el);
                end
            end
            if (beats == stall_k && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = (int'($urandom_range(99)) < ready_pct);
            end
            out_ready = rdy;
            hold = out_valid && !rdy;
            pw = out_w;
            px = out_x;
            if (out_valid && rdy) beats++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        vectors++;
        if (beats != exp_beats) begin
            fails++;
            $display("FAIL stream_count got %0d beats want %0d", beats, exp_beats);
        end
        vectors++;
        if ({done, busy, out_valid} !== 3'b110) begin
            fails++;
            $display("FAIL done_pulse got done/busy/valid=%b%b%b want 110", done, busy, out_valid);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL after_done got done/busy=%b%b want 00", done, busy);
        end
    endtask

    task automatic check_idle_zero(input string name);
        vectors++;
        if ({in_ready, out_valid, out_first, out_last, done, busy, dim_err, out_w, out_x} !== '0) begin
            fails++;
            $display("FAIL %s got rdy=%b v=%b f=%b l=%b d=%b b=%b e=%b w=%h x=%h want all 0", name,
                     in_ready, out_valid, out_first, out_last, done, busy, dim_err, out_w, out_x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_released");
    endtask

    task automatic try_bad(input int rw, input int cw, input int rx, input int cx, input string name);
        row_w = DIMW'(rw); col_w = DIMW'(cw); row_x = DIMW'(rx); col_x = DIMW'(cx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({dim_err, busy, in_ready} !== 3'b100) begin
            fails++;
            $display("FAIL %s got err/busy/rdy=%b%b%b want 100", name, dim_err, busy, in_ready);
        end
        @(negedge clk);
        vectors++;
        if ({dim_err, busy, in_ready} !== 3'b000) begin
            fails++;
            $display("FAIL %s_after got err/busy/rdy=%b%b%b want 000", name, dim_err, busy, in_ready);
        end
    endtask

    task automatic test_dim_err();
        try_bad(3, 2, 3, 3, "dim_inner");
        try_bad(0, 3, 3, 3, "dim_zero");
        try_bad(3, 3, 3, 4, "dim_over");
        try_bad(4, 3, 3, 3, "dim_over_rw");
    endtask

    task automatic test_full_3x3();
        fill_seq(3, 3, 3, 1, -1);
        load(0, -1);
        collect(3, 100, -1, 0);
    endtask

    task automatic test_replay();
        try_bad(2, 3, 2, 3, "dim_keep");
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        collect(3, 100, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        repeat (2) begin
            vectors++;
            if ({busy, out_valid} !== 2'b00) begin
                fails++;
                $display("FAIL replay_after_rst got busy/valid=%b%b want 00", busy, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rect();
        fill_seq(2, 3, 2, 1, 1);
        load(0, -1);
        collect(3, 100, -1, 0);
    endtask

    task automatic test_backpressure();
        fill_seq(3, 3, 3, 1, -1);
        load(40, -1);
        collect(3, 100, 1, 2);
    endtask

    task automatic test_rst_abort();
        fill_rand(3, 3, 3);
        load(0, 13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort_idle");
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        vectors++;
        if ({busy, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL abort_replay got busy/valid=%b%b want 00", busy, out_valid);
        end
        fill_rand(3, 3, 3);
        load(20, -1);
        collect(3, 70, -1, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            fill_rand(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            load(int'($urandom_range(50)), -1);
            collect(m_cw, int'($urandom_range(30, 100)), -1, 0);
            if (it % 3 == 0) begin
                replay = 1'b1;
                @(negedge clk);
                replay = 1'b0;
                collect(m_cw, int'($urandom_range(30, 100)), -1, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; replay = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; row_w = '0; col_w = '0; row_x = '0; col_x = '0;
        test_reset();
        test_dim_err();
        test_full_3x3();
        test_replay();
        test_rect();
        test_backpressure();
        test_rst_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
